// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by an on-chip word array. It is a simulation and bring-up
// stand-in for a DDR controller. Write and read channels run independently.
// Every burst is treated as INCR at full data width, and the word index wraps
// modulo the array depth.
module axi_ram_slave #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 30,
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    // write address channel
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awlock,
    input  logic [3:0]          s_axi_awcache,
    input  logic [2:0]          s_axi_awprot,
    input  logic [3:0]          s_axi_awqos,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    // write data channel
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    // write response channel
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    // read address channel
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arlock,
    input  logic [3:0]          s_axi_arcache,
    input  logic [2:0]          s_axi_arprot,
    input  logic [3:0]          s_axi_arqos,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    // read data channel
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Merge the strobed bytes of new_word into old_word.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_r [MEM_DEPTH];

    w_state_t          w_state_r;
    logic [ID_W-1:0]   w_id_r;
    logic [IDX_W-1:0]  w_idx_r;
    logic [7:0]        w_len_r;
    logic [7:0]        w_cnt_r;

    r_state_t          r_state_r;
    logic [IDX_W-1:0]  r_idx_r;
    logic [7:0]        r_len_r;
    logic [7:0]        r_cnt_r;

    logic              mem_we_s;
    logic              w_final_s;
    logic [IDX_W-1:0]  aw_idx_s;
    logic [IDX_W-1:0]  ar_idx_s;
    logic              unused_s;

    // The word index drops the byte offset; higher address bits alias.
    assign aw_idx_s  = s_axi_awaddr[OFF_W+IDX_W-1:OFF_W];
    assign ar_idx_s  = s_axi_araddr[OFF_W+IDX_W-1:OFF_W];
    assign mem_we_s  = (w_state_r == W_DATA) && s_axi_wvalid && s_axi_wready;
    // A burst ends on its nominal last beat or on the first wlast, whichever is earlier.
    assign w_final_s = (w_cnt_r == w_len_r) || s_axi_wlast;

    // These attribute inputs and the high address bits do not affect behaviour.
    assign unused_s = ^{s_axi_awaddr, s_axi_awsize, s_axi_awburst, s_axi_awlock,
                        s_axi_awcache, s_axi_awprot, s_axi_awqos,
                        s_axi_araddr, s_axi_arsize, s_axi_arburst, s_axi_arlock,
                        s_axi_arcache, s_axi_arprot, s_axi_arqos};

    // Array write port: byte-masked store. Contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[w_idx_r] <= merge_bytes(mem_r[w_idx_r], s_axi_wdata, s_axi_wstrb);
        end
    end

    // Write FSM: accept AW, collect beats, then return a single response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r     <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= {ID_W{1'b0}};
            s_axi_bresp   <= RESP_OKAY;
            w_id_r        <= {ID_W{1'b0}};
            w_idx_r       <= {IDX_W{1'b0}};
            w_len_r       <= 8'd0;
            w_cnt_r       <= 8'd0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        w_id_r        <= s_axi_awid;
                        w_idx_r       <= aw_idx_s;
                        w_len_r       <= s_axi_awlen;
                        w_cnt_r       <= 8'd0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state_r     <= W_DATA;
                    end else begin
                        s_axi_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (mem_we_s) begin
                        w_idx_r <= w_idx_r + IDX_ONE;
                        w_cnt_r <= w_cnt_r + 8'd1;
                        if (w_final_s) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= w_id_r;
                            // OKAY only when wlast lands exactly on the nominal last beat.
                            s_axi_bresp  <= ((w_cnt_r == w_len_r) && s_axi_wlast) ?
                                            RESP_OKAY : RESP_SLVERR;
                            w_state_r    <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bvalid && s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state_r     <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r     <= W_IDLE;
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b0;
                    s_axi_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: accept AR, then stream words back-to-back while rready allows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r     <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= {ID_W{1'b0}};
            s_axi_rdata   <= {DATA_W{1'b0}};
            s_axi_rresp   <= RESP_OKAY;
            r_idx_r       <= {IDX_W{1'b0}};
            r_len_r       <= 8'd0;
            r_cnt_r       <= 8'd0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_rid     <= s_axi_arid;
                        s_axi_rdata   <= mem_r[ar_idx_s];
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        r_idx_r       <= ar_idx_s + IDX_ONE;
                        r_len_r       <= s_axi_arlen;
                        r_cnt_r       <= 8'd0;
                        r_state_r     <= R_DATA;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rvalid && s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state_r     <= R_IDLE;
                        end else begin
                            // Next word loads on the same edge so beats have no bubbles.
                            s_axi_rdata <= mem_r[r_idx_r];
                            s_axi_rlast <= ((r_cnt_r + 8'd1) == r_len_r);
                            r_idx_r     <= r_idx_r + IDX_ONE;
                            r_cnt_r     <= r_cnt_r + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state_r     <= R_IDLE;
                    s_axi_arready <= 1'b0;
                    s_axi_rvalid  <= 1'b0;
                    s_axi_rlast   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Randomised bench for axi_ram_slave: a word-array model and expected-response
// queues, plus one negedge compare process that checks the read and response
// channels on every valid cycle.
module tb_axi_ram_slave;

    localparam int DEPTH = 1024;
    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  s_axi_awid;
    logic [29:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_arid;
    logic [29:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    always #5 clk = ~clk;

    axi_ram_slave dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(3'd3), .s_axi_awburst(2'b01), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awqos(4'd0),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(3'd3), .s_axi_arburst(2'b01), .s_axi_arlock(1'b0),
        .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arqos(4'd0),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    typedef struct { logic [3:0] id; logic [63:0] data; logic last; } rexp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

    logic [63:0] mem_model [DEPTH];
    rexp_t       exp_r [$];
    bexp_t       exp_b [$];
    logic [63:0] got_q [$];
    logic [1:0]  last_bresp;
    bit          bp_en = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          r_stall_prev = 1'b0;
    bit          b_stall_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no handshake within %0d cycles at %0t", name, LIMIT, $time);
    endtask

    function automatic int widx(input logic [29:0] addr);
        return int'((addr >> 3) % DEPTH);
    endfunction

    // Backpressure on the response and read-data channels.
    initial begin
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            s_axi_bready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axi_rready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: every valid cycle is checked against the queue heads.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_ctrl", {56'd0, s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid,
                               s_axi_rvalid, s_axi_rlast, s_axi_bresp}, 64'd0);
            check("rst_data", s_axi_rdata, 64'd0);
            check("rst_ids", {54'd0, s_axi_rresp, s_axi_bid, s_axi_rid}, 64'd0);
            r_stall_prev = 1'b0;
            b_stall_prev = 1'b0;
        end else begin
            if (r_stall_prev) check("r_hold", {63'd0, s_axi_rvalid}, 64'd1);
            if (s_axi_rvalid) begin
                if (exp_r.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL r_unexpected: got rvalid=1 expected 0 at %0t", $time);
                end else begin
                    check("rdata", s_axi_rdata, exp_r[0].data);
                    check("rlast", {63'd0, s_axi_rlast}, {63'd0, exp_r[0].last});
                    check("rid", {60'd0, s_axi_rid}, {60'd0, exp_r[0].id});
                    check("rresp", {62'd0, s_axi_rresp}, 64'd0);
                    if (s_axi_rready) void'(exp_r.pop_front());
                end
            end
            r_stall_prev = s_axi_rvalid && !s_axi_rready;
            if (b_stall_prev) check("b_hold", {63'd0, s_axi_bvalid}, 64'd1);
            if (s_axi_bvalid) begin
                if (exp_b.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL b_unexpected: got bvalid=1 expected 0 at %0t", $time);
                end else begin
                    check("bid", {60'd0, s_axi_bid}, {60'd0, exp_b[0].id});
                    check("bresp", {62'd0, s_axi_bresp}, {62'd0, exp_b[0].resp});
                    if (s_axi_bready) void'(exp_b.pop_front());
                end
            end
            b_stall_prev = s_axi_bvalid && !s_axi_bready;
        end
    end

    task automatic do_aw(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len);
        int t = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
        do begin @(negedge clk); t++; end while (!s_axi_awready && t < LIMIT);
        if (!s_axi_awready) timeout("aw_handshake");
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len);
        int t = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
        do begin @(negedge clk); t++; end while (!s_axi_arready && t < LIMIT);
        if (!s_axi_arready) timeout("ar_handshake");
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    // dmode: 0 random data, 1 dval+beat, 2 constant dval. last_at < 0 means no wlast.
    task automatic write_burst(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len,
                               input int last_at, input int dmode, input logic [63:0] dval,
                               input bit rnd_strb, input logic [7:0] strb);
        int nend, idx, t;
        bit got_b;
        logic [1:0] resp;
        nend = (last_at >= 0 && last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
        resp = (last_at == int'(len)) ? 2'b00 : 2'b10;
        idx  = widx(addr);
        do_aw(id, addr, len);
        for (int k = 0; k < nend; k++) begin
            if (bp_en) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            s_axi_wdata = (dmode == 0) ? {$urandom, $urandom} : (dmode == 1) ? dval + 64'(k) : dval;
            s_axi_wstrb = rnd_strb ? 8'($urandom) : strb;
            s_axi_wlast = (k == last_at);
            s_axi_wvalid = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!s_axi_wready && t < LIMIT);
            if (!s_axi_wready) timeout("w_handshake");
            for (int b = 0; b < 8; b++)
                if (s_axi_wstrb[b]) mem_model[(idx + k) % DEPTH][8*b +: 8] = s_axi_wdata[8*b +: 8];
            if (k == nend - 1) exp_b.push_back('{id: id, resp: resp});
            @(posedge clk); #1;
            s_axi_wvalid = 1'b0;
            s_axi_wlast = 1'b0;
        end
        got_b = 1'b0;
        t = 0;
        while (!got_b && t < LIMIT) begin
            @(negedge clk); t++;
            if (t == 1) check("w_closed", {63'd0, s_axi_wready}, 64'd0);
            if (s_axi_bvalid && s_axi_bready) begin got_b = 1'b1; last_bresp = s_axi_bresp; end
        end
        if (!got_b) timeout("b_handshake");
        @(posedge clk); #1;
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len);
        int idx, cyc, beats;
        idx = widx(addr);
        got_q.delete();
        do_ar(id, addr, len);
        for (int k = 0; k <= int'(len); k++)
            exp_r.push_back('{id: id, data: mem_model[(idx + k) % DEPTH], last: (k == int'(len))});
        cyc = 0; beats = 0;
        while (beats < int'(len) + 1 && cyc < LIMIT) begin
            @(negedge clk); cyc++;
            if (cyc == 1 && !bp_en) check("r_latency", {63'd0, s_axi_rvalid}, 64'd1);
            if (s_axi_rvalid && s_axi_rready) begin got_q.push_back(s_axi_rdata); beats++; end
        end
        @(posedge clk); #1;
        if (beats < int'(len) + 1) timeout("r_beats");
        else if (!bp_en) check("r_nobubble", 64'(cyc), 64'(int'(len) + 1));
    endtask

    task automatic set_bp(input bit en);
        bp_en = en;
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [63:0] oldv, newv;
        int t;
        rst_n = 1'b0;
        s_axi_awid = 4'd0; s_axi_awaddr = 30'd0; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b0;
        s_axi_wdata = 64'd0; s_axi_wstrb = 8'd0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_arid = 4'd0; s_axi_araddr = 30'd0; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", {61'd0, s_axi_awready, s_axi_arready, s_axi_wready}, 64'd6);

        // Preload the whole array so every later read has a known model value.
        for (int b = 0; b < 4; b++) begin
            set_bp(b[0]);
            write_burst(4'(b), 30'(b * 2048), 8'd255, 255, 0, 64'd0, 1'b0, 8'hFF);
        end
        set_bp(1'b0);

        // Single write then read.
        write_burst(4'h3, 30'h40, 8'd0, 0, 2, 64'h1122334455667788, 1'b0, 8'hFF);
        check("t1_bresp", {62'd0, last_bresp}, 64'd0);
        read_burst(4'h5, 30'h40, 8'd0);
        check("t1_rdata", got_q[0], 64'h1122334455667788);

        // 16-beat incrementing burst read back without stalls.
        write_burst(4'h1, 30'h100, 8'd15, 15, 1, 64'h1000, 1'b0, 8'hFF);
        read_burst(4'h2, 30'h100, 8'd15);
        for (int k = 0; k < 16; k++) check("t2_rdata", got_q[k], 64'h1000 + 64'(k));

        // Partial strobe.
        write_burst(4'h4, 30'h200, 8'd0, 0, 2, 64'hFFFFFFFFFFFFFFFF, 1'b0, 8'hFF);
        write_burst(4'h4, 30'h200, 8'd0, 0, 2, 64'h0, 1'b0, 8'h0F);
        read_burst(4'h4, 30'h200, 8'd0);
        check("t3_rdata", got_q[0], 64'hFFFFFFFF00000000);

        // Wrap from the top word to word 0, and address aliasing.
        write_burst(4'h7, 30'h1FF8, 8'd1, 1, 1, 64'hAAAA0000, 1'b0, 8'hFF);
        read_burst(4'h7, 30'h0, 8'd0);
        check("wrap_word0", got_q[0], 64'hAAAA0001);
        read_burst(4'h8, 30'h3FF8, 8'd1);
        check("alias_b0", got_q[0], 64'hAAAA0000);
        check("alias_b1", got_q[1], 64'hAAAA0001);

        // Early wlast and missing wlast both end in SLVERR.
        write_burst(4'h9, 30'h600, 8'd3, 1, 0, 64'd0, 1'b0, 8'hFF);
        check("early_bresp", {62'd0, last_bresp}, 64'd2);
        read_burst(4'h9, 30'h600, 8'd3);
        write_burst(4'hA, 30'h700, 8'd2, -1, 0, 64'd0, 1'b0, 8'hFF);
        check("nolast_bresp", {62'd0, last_bresp}, 64'd2);
        read_burst(4'hA, 30'h700, 8'd2);

        // Concurrent AW and AR on disjoint regions.
        fork
            write_burst(4'hB, 30'(500 * 8), 8'd3, 3, 0, 64'd0, 1'b0, 8'hFF);
            read_burst(4'hC, 30'(600 * 8), 8'd3);
        join

        // Read and write of the same word on one edge: the read sees the old value.
        oldv = mem_model[700];
        newv = {$urandom, $urandom};
        do_aw(4'h6, 30'(700 * 8), 8'd0);
        s_axi_wdata = newv; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_arid = 4'hD; s_axi_araddr = 30'(700 * 8); s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
        exp_r.push_back('{id: 4'hD, data: oldv, last: 1'b1});
        exp_b.push_back('{id: 4'h6, resp: 2'b00});
        mem_model[700] = newv;
        @(negedge clk);
        check("rbw_ready", {62'd0, s_axi_wready, s_axi_arready}, 64'd3);
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
        t = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && t < 50) begin @(posedge clk); t++; end
        #1;
        if (exp_r.size() != 0 || exp_b.size() != 0) timeout("rbw_drain");
        read_burst(4'hD, 30'(700 * 8), 8'd0);
        check("rbw_new", got_q[0], newv);

        // Randomised traffic with backpressure.
        for (int i = 0; i < 40; i++) begin
            logic [29:0] a;
            logic [7:0]  l;
            a = 30'($urandom);
            l = 8'($urandom_range(0, 15));
            set_bp(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1)
                write_burst(4'($urandom), a, l, int'(l), 0, 64'd0, 1'b1, 8'hFF);
            else
                read_burst(4'($urandom), a, l);
        end
        set_bp(1'b0);

        // Reset in the middle of a read burst, then a normal read.
        do_ar(4'hE, 30'h800, 8'd7);
        for (int k = 0; k < 8; k++)
            exp_r.push_back('{id: 4'hE, data: mem_model[256 + k], last: (k == 7)});
        repeat (3) @(negedge clk);
        #2;
        exp_r.delete();
        rst_n = 1'b0;
        #1;
        check("midrst_r", {61'd0, s_axi_rvalid, s_axi_rlast, s_axi_arready}, 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        read_burst(4'hF, 30'h800, 8'd7);
        check("post_rst_b0", got_q[0], mem_model[256]);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
